// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkg : shared Gray-code and lane helpers for the FIFO / RAM blocks
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

    // Binary bit i of a Gray word is the XOR of Gray bits i and above.
    function automatic logic gray_bit(input logic [31:0] gray, input int unsigned idx);
        return ^(gray >> idx);
    endfunction

    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
//------------------------------------------------------------------------------
// gray2bin : combinational Gray-to-binary converter, W bits wide
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gray2bin
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = gray_bit(32'(i_gray), i);
    end

endmodule

`default_nettype wire

// File: rtl/sync_dpram.sv
//------------------------------------------------------------------------------
// sync_dpram : 1W/1R synchronous RAM, lane write enables, write-first collisions
// Revision   : 1.0   Option macro: SYNC_DPRAM_OUTREG_EN (extra output stage)
//------------------------------------------------------------------------------
`default_nettype none

module sync_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LANE_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int GRAY_ADDR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [DATA_W/LANE_W-1:0] wlane,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     ren,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     coll
);

    localparam int LANES = lane_count(DATA_W, LANE_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] w_waddr_g2b;
    logic [ADDR_W-1:0] w_raddr_g2b;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_raddr;
    logic              w_wr;
    logic              w_coll;
    logic [DATA_W-1:0] w_rd_word;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid1;
    logic              r_coll1;

    gray2bin #(.W(ADDR_W)) u_wa_g2b (.i_gray(waddr), .o_bin(w_waddr_g2b));
    gray2bin #(.W(ADDR_W)) u_ra_g2b (.i_gray(raddr), .o_bin(w_raddr_g2b));

    assign w_waddr = (GRAY_ADDR != 0) ? w_waddr_g2b : waddr;
    assign w_raddr = (GRAY_ADDR != 0) ? w_raddr_g2b : raddr;

    // An all-zero lane mask is not a write, so it can never collide.
    assign w_wr   = wen && (|wlane);
    assign w_coll = w_wr && (w_waddr == w_raddr);

    always_comb begin
        w_rd_word = r_mem[w_raddr];
        if (w_coll) begin
            for (int k = 0; k < LANES; k++) begin
                if (wlane[k]) begin
                    w_rd_word[k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Storage has no reset; writes are simply blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            for (int k = 0; k < LANES; k++) begin
                if (wlane[k]) begin
                    r_mem[w_waddr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata1  <= '0;
            r_rvalid1 <= 1'b0;
            r_coll1   <= 1'b0;
        end else begin
            r_rvalid1 <= ren;
            r_coll1   <= ren && w_coll;
            if (ren) begin
                r_rdata1 <= w_rd_word;
            end
        end
    end

`ifdef SYNC_DPRAM_OUTREG_EN
    logic [DATA_W-1:0] r_rdata2;
    logic              r_rvalid2;
    logic              r_coll2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata2  <= '0;
            r_rvalid2 <= 1'b0;
            r_coll2   <= 1'b0;
        end else begin
            r_rdata2  <= r_rdata1;
            r_rvalid2 <= r_rvalid1;
            r_coll2   <= r_coll1;
        end
    end

    assign rdata  = r_rdata2;
    assign rvalid = r_rvalid2;
    assign coll   = r_coll2;
`else
    assign rdata  = r_rdata1;
    assign rvalid = r_rvalid1;
    assign coll   = r_coll1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_dpram.sv
//------------------------------------------------------------------------------
// tb_sync_dpram : randomized bench for sync_dpram against a behavioural model
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_dpram;

`ifdef SYNC_DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic [1:0] wlane;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       ren;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic       rvalid;
    logic       coll;

    int total;
    int bad;
    bit chk_en;

    sync_dpram #(
        .DATA_W(8), .LANE_W(4), .ADDR_W(4), .GRAY_ADDR(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wlane(wlane), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata),
        .rvalid(rvalid), .coll(coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory array plus an output delay line of depth LAT.
    logic [7:0] m_mem [16];
    logic [7:0] dl_d [LAT];
    logic       dl_v [LAT];
    logic       dl_c [LAT];
    logic [3:0] m_wa, m_ra;
    logic [7:0] m_new, m_rd, m_nd;
    logic       m_wr, m_hit;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b = 4'd0;
        for (int i = 0; i < 4; i++) b = b ^ (g >> i);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dl_d[i] = 8'h00;
                dl_v[i] = 1'b0;
                dl_c[i] = 1'b0;
            end
        end else begin
            m_wa  = g2b(waddr);
            m_ra  = g2b(raddr);
            m_wr  = wen && (wlane != 2'b00);
            m_new = m_mem[m_wa];
            if (wlane[0]) m_new[3:0] = wdata[3:0];
            if (wlane[1]) m_new[7:4] = wdata[7:4];
            m_hit = m_wr && (m_wa == m_ra);
            m_rd  = m_hit ? m_new : m_mem[m_ra];
            m_nd  = ren ? m_rd : dl_d[0];
            for (int i = LAT - 1; i > 0; i--) begin
                dl_d[i] = dl_d[i-1];
                dl_v[i] = dl_v[i-1];
                dl_c[i] = dl_c[i-1];
            end
            dl_d[0] = m_nd;
            dl_v[0] = ren;
            dl_c[0] = ren && m_hit;
            if (m_wr) m_mem[m_wa] = m_new;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model rdata",  32'(rdata),  32'(dl_d[LAT-1]));
            check("model rvalid", 32'(rvalid), 32'(dl_v[LAT-1]));
            check("model coll",   32'(coll),   32'(dl_c[LAT-1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen   = 1'b0;
        ren   = 1'b0;
        wlane = 2'b00;
    endtask

    task automatic wr(input logic [3:0] ga, input logic [7:0] d, input logic [1:0] ln);
        wen = 1'b1; waddr = ga; wdata = d; wlane = ln; ren = 1'b0;
        cyc();
        idle();
    endtask

    // Issue a read and stop at the negedge where its result is visible.
    task automatic rd_to_out(input logic [3:0] ga);
        ren = 1'b1; raddr = ga;
        cyc();
        idle();
        repeat (LAT - 1) cyc();
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst_n = 1'b0; idle(); waddr = '0; raddr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rdata",  32'(rdata),  32'h0);
        check("reset rvalid", 32'(rvalid), 32'h0);
        check("reset coll",   32'(coll),   32'h0);
        cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Define every word so all later reads have known data.
        for (int a = 0; a < 16; a++) wr(4'(a), 8'($urandom), 2'b11);

        // Gray 0011 is binary 2.
        wen = 1'b1; waddr = 4'b0011; wdata = 8'hA5; wlane = 2'b11;
        cyc();
        idle();
        rd_to_out(4'b0011);
        check("gray read data",  32'(rdata),  32'hA5);
        check("gray read valid", 32'(rvalid), 32'h1);

        wr(4'b0011, 8'h3C, 2'b01);
        rd_to_out(4'b0011);
        check("lane merge", 32'(rdata), 32'hAC);

        // Binary 7 is Gray 0100.
        wr(4'b0100, 8'h11, 2'b11);
        wen = 1'b1; waddr = 4'b0100; wdata = 8'hFF; wlane = 2'b10;
        ren = 1'b1; raddr = 4'b0100;
        cyc();
        idle();
        repeat (LAT - 1) cyc();
        @(negedge clk);
        check("collision data", 32'(rdata), 32'hF1);
        check("collision coll", 32'(coll),  32'h1);
        cyc();
        @(negedge clk);
        check("collision pulse end", 32'(coll), 32'h0);

        // Binary 9 is Gray 1101.
        wr(4'b1101, 8'h5A, 2'b11);
        rd_to_out(4'b1101);
        check("hold first", 32'(rdata), 32'h5A);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("hold data",  32'(rdata),  32'h5A);
            check("hold valid", 32'(rvalid), 32'h0);
        end

        ren = 1'b1; raddr = 4'b1101;
        cyc();
        idle();
        rst_n = 1'b0;
        #1;
        check("midreset rdata",  32'(rdata),  32'h0);
        check("midreset rvalid", 32'(rvalid), 32'h0);
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            cyc();
            @(negedge clk);
            check("no late rvalid", 32'(rvalid), 32'h0);
        end
        rd_to_out(4'b1101);
        check("after reset data",  32'(rdata),  32'h5A);
        check("after reset valid", 32'(rvalid), 32'h1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                idle();
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            wen   = 1'($urandom);
            wlane = 2'($urandom);
            waddr = 4'($urandom);
            wdata = 8'($urandom);
            ren   = 1'($urandom);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            cyc();
        end
        idle();
        repeat (LAT + 1) cyc();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
